// File: rtl/mux_16_if.sv
// Bundled view of the 16-way selector's data path (select code, sources, result).
interface mux_16_if #(
   parameter int unsigned BITS = 32
);
   logic [3:0]      addr;
   logic [BITS-1:0] data [16];
   logic [BITS-1:0] out;

   // Driver side: presents select code and sources, observes the result.
   modport master (output addr, output data, input out);

   // Selector side: consumes select code and sources, produces the result.
   modport slave (input addr, input data, output out);
endinterface

// File: rtl/mux_16.sv
// 16-to-1 data selector; combinational by default, optional one-cycle output register.
module mux_16 #(
   parameter int unsigned BITS       = 32,
   parameter bit          REGISTERED = 1'b0
) (
   input  logic            clk,
   input  logic            nrst,
   input  logic [3:0]      addr,
   input  logic [BITS-1:0] in0,
   input  logic [BITS-1:0] in1,
   input  logic [BITS-1:0] in2,
   input  logic [BITS-1:0] in3,
   input  logic [BITS-1:0] in4,
   input  logic [BITS-1:0] in5,
   input  logic [BITS-1:0] in6,
   input  logic [BITS-1:0] in7,
   input  logic [BITS-1:0] in8,
   input  logic [BITS-1:0] in9,
   input  logic [BITS-1:0] in10,
   input  logic [BITS-1:0] in11,
   input  logic [BITS-1:0] in12,
   input  logic [BITS-1:0] in13,
   input  logic [BITS-1:0] in14,
   input  logic [BITS-1:0] in15,
   output logic [BITS-1:0] out
);

   logic [BITS-1:0] sel;

   // Explicit decode of every select code; the zero default only covers an unknown addr.
   always_comb begin
      sel = '0;
      case (addr)
         4'd0:  sel = in0;
         4'd1:  sel = in1;
         4'd2:  sel = in2;
         4'd3:  sel = in3;
         4'd4:  sel = in4;
         4'd5:  sel = in5;
         4'd6:  sel = in6;
         4'd7:  sel = in7;
         4'd8:  sel = in8;
         4'd9:  sel = in9;
         4'd10: sel = in10;
         4'd11: sel = in11;
         4'd12: sel = in12;
         4'd13: sel = in13;
         4'd14: sel = in14;
         4'd15: sel = in15;
         default: sel = '0;
      endcase
   end

   generate
      if (REGISTERED) begin : g_reg
         logic [BITS-1:0] out_q;

         // Capture the selected source each rising edge; reset clears it at once.
         always_ff @(posedge clk or negedge nrst) begin
            if (!nrst) begin
               out_q <= '0;
            end else begin
               out_q <= sel;
            end
         end

         assign out = out_q;
      end else begin : g_comb
         // Clock and reset have no role in the stateless variant.
         logic unused_ok;
         assign unused_ok = clk ^ nrst;

         assign out = sel;
      end
   endgenerate

endmodule

// File: tb/tb_mux_16.sv
// Scoreboard bench for mux_16: combinational/registered variants and narrow widths.
module tb_mux_16;

   logic clk = 1'b0;
   logic r_nrst;
   logic c_nrst;

   int unsigned errors = 0;
   int unsigned checks = 0;

   logic [31:0] sb_q [$];
   logic [31:0] m32 [16];
   logic [7:0]  m8  [16];

   always #5 clk = ~clk;

   mux_16_if #(.BITS(32)) if_c ();
   mux_16_if #(.BITS(32)) if_r ();
   mux_16_if #(.BITS(8))  if_8 ();
   mux_16_if #(.BITS(1))  if_1 ();

   mux_16 #(.BITS(32), .REGISTERED(1'b0)) u_comb (
      .clk(1'b0), .nrst(c_nrst), .addr(if_c.addr),
      .in0(if_c.data[0]),   .in1(if_c.data[1]),   .in2(if_c.data[2]),   .in3(if_c.data[3]),
      .in4(if_c.data[4]),   .in5(if_c.data[5]),   .in6(if_c.data[6]),   .in7(if_c.data[7]),
      .in8(if_c.data[8]),   .in9(if_c.data[9]),   .in10(if_c.data[10]), .in11(if_c.data[11]),
      .in12(if_c.data[12]), .in13(if_c.data[13]), .in14(if_c.data[14]), .in15(if_c.data[15]),
      .out(if_c.out)
   );

   mux_16 #(.BITS(32), .REGISTERED(1'b1)) u_reg (
      .clk(clk), .nrst(r_nrst), .addr(if_r.addr),
      .in0(if_r.data[0]),   .in1(if_r.data[1]),   .in2(if_r.data[2]),   .in3(if_r.data[3]),
      .in4(if_r.data[4]),   .in5(if_r.data[5]),   .in6(if_r.data[6]),   .in7(if_r.data[7]),
      .in8(if_r.data[8]),   .in9(if_r.data[9]),   .in10(if_r.data[10]), .in11(if_r.data[11]),
      .in12(if_r.data[12]), .in13(if_r.data[13]), .in14(if_r.data[14]), .in15(if_r.data[15]),
      .out(if_r.out)
   );

   mux_16 #(.BITS(8)) u_b8 (
      .clk(1'b0), .nrst(1'b1), .addr(if_8.addr),
      .in0(if_8.data[0]),   .in1(if_8.data[1]),   .in2(if_8.data[2]),   .in3(if_8.data[3]),
      .in4(if_8.data[4]),   .in5(if_8.data[5]),   .in6(if_8.data[6]),   .in7(if_8.data[7]),
      .in8(if_8.data[8]),   .in9(if_8.data[9]),   .in10(if_8.data[10]), .in11(if_8.data[11]),
      .in12(if_8.data[12]), .in13(if_8.data[13]), .in14(if_8.data[14]), .in15(if_8.data[15]),
      .out(if_8.out)
   );

   mux_16 #(.BITS(1)) u_b1 (
      .clk(1'b0), .nrst(1'b1), .addr(if_1.addr),
      .in0(if_1.data[0]),   .in1(if_1.data[1]),   .in2(if_1.data[2]),   .in3(if_1.data[3]),
      .in4(if_1.data[4]),   .in5(if_1.data[5]),   .in6(if_1.data[6]),   .in7(if_1.data[7]),
      .in8(if_1.data[8]),   .in9(if_1.data[9]),   .in10(if_1.data[10]), .in11(if_1.data[11]),
      .in12(if_1.data[12]), .in13(if_1.data[13]), .in14(if_1.data[14]), .in15(if_1.data[15]),
      .out(if_1.out)
   );

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
      end
   endtask

   task automatic sb_push(input logic [31:0] v);
      sb_q.push_back(v);
   endtask

   task automatic sb_check(input string tag, input logic [31:0] act);
      logic [31:0] exp;
      exp = (sb_q.size() > 0) ? sb_q.pop_front() : 'x;
      check_val(tag, act, exp);
   endtask

   // Watchdog so the run always ends.
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [7:0]  one8;
      logic [3:0]  a;
      logic [31:0] held;

      r_nrst = 1'b0;
      c_nrst = 1'b1;

      // Combinational: address sweep with fixed pattern.
      for (int n = 0; n < 16; n++) begin
         m32[n] = 32'h1000_0000 + 32'(n);
         if_c.data[n] = m32[n];
      end
      for (int n = 0; n < 16; n++) begin
         if_c.addr = 4'(n);
         sb_push(32'h1000_0000 + 32'(n));
         #1 sb_check("comb_sweep", if_c.out);
      end

      // Non-selected inputs must not disturb the output; selected input follows.
      if_c.addr = 4'd5;
      sb_push(32'h1000_0005);
      if_c.data[4] = ~if_c.data[4];
      if_c.data[6] = ~if_c.data[6];
      #1 sb_check("comb_nonsel", if_c.out);
      if_c.data[4] = 32'hFFFF_FFFF;
      if_c.data[6] = 32'h0000_0000;
      sb_push(32'h1000_0005);
      #1 sb_check("comb_nonsel2", if_c.out);
      if_c.data[5] = 32'hDEAD_BEEF;
      sb_push(32'hDEAD_BEEF);
      #1 sb_check("comb_follow", if_c.out);

      // Reset low must not affect the stateless variant.
      c_nrst = 1'b0;
      for (int n = 0; n < 16; n++) if_c.data[n] = m32[n];
      for (int n = 15; n >= 0; n--) begin
         if_c.addr = 4'(n);
         sb_push(32'h1000_0000 + 32'(n));
         #1 sb_check("comb_rst_low", if_c.out);
      end
      c_nrst = 1'b1;

      // Random selections against the bench's own copy of the sources.
      for (int i = 0; i < 16; i++) begin
         for (int n = 0; n < 16; n++) begin
            m32[n] = $urandom;
            if_c.data[n] = m32[n];
         end
         a = 4'($urandom_range(0, 15));
         if_c.addr = a;
         sb_push(m32[a]);
         #1 sb_check("comb_rand", if_c.out);
      end

      // Walking ones, 8-bit width.
      one8 = 8'd1;
      for (int b = 0; b < 8; b++) begin
         for (int n = 0; n < 16; n++) begin
            m8[n] = one8 << ((n + b) % 8);
            if_8.data[n] = m8[n];
         end
         for (int n = 0; n < 16; n++) begin
            if_8.addr = 4'(n);
            sb_push(32'(m8[n]));
            #1 sb_check("b8_walk", 32'(if_8.out));
         end
      end

      // Walking one across inputs, 1-bit width.
      for (int k = 0; k < 16; k++) begin
         for (int n = 0; n < 16; n++) if_1.data[n] = (n == k) ? 1'b1 : 1'b0;
         for (int n = 0; n < 16; n++) begin
            if_1.addr = 4'(n);
            sb_push((n == k) ? 32'd1 : 32'd0);
            #1 sb_check("b1_walk", 32'(if_1.out));
         end
      end

      // Registered: reset state and first capture after release.
      for (int n = 0; n < 16; n++) begin
         m32[n] = 32'h0101_0101 * 32'(n + 1);
         if_r.data[n] = m32[n];
      end
      if_r.addr = 4'd0;
      @(negedge clk);
      sb_push(32'h0);
      #1 sb_check("reg_reset", if_r.out);
      @(posedge clk);
      sb_push(32'h0);
      #1 sb_check("reg_reset_hold", if_r.out);
      @(negedge clk);
      r_nrst = 1'b1;
      if_r.addr = 4'd3;
      m32[3] = 32'hA5A5_A5A5;
      if_r.data[3] = m32[3];
      sb_push(32'h0);
      #1 sb_check("reg_no_edge_yet", if_r.out);
      @(posedge clk);
      sb_push(32'hA5A5_A5A5);
      #1 sb_check("reg_first_cap", if_r.out);
      if_r.addr = 4'd7;
      sb_push(32'hA5A5_A5A5);
      #2 sb_check("reg_hold_addr", if_r.out);
      @(posedge clk);
      sb_push(m32[7]);
      #1 sb_check("reg_addr7", if_r.out);

      // Registered random traffic with mid-cycle perturbation.
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         for (int n = 0; n < 16; n++) begin
            m32[n] = $urandom | 32'h1;
            if_r.data[n] = m32[n];
         end
         a = 4'($urandom_range(0, 15));
         if_r.addr = a;
         held = m32[a];
         sb_push(held);
         @(posedge clk);
         #1 sb_check("reg_rand", if_r.out);
         if_r.addr = a + 4'd1;
         for (int n = 0; n < 16; n++) if_r.data[n] = ~m32[n];
         sb_push(held);
         #1 sb_check("reg_rand_hold", if_r.out);
      end

      // Mid-operation reset pulse between edges: immediate clear, held, clean restart.
      @(negedge clk);
      #2 r_nrst = 1'b0;
      sb_push(32'h0);
      #1 sb_check("reg_async_clr", if_r.out);
      @(posedge clk);
      sb_push(32'h0);
      #1 sb_check("reg_clr_held", if_r.out);
      @(negedge clk);
      r_nrst = 1'b1;
      if_r.addr = 4'd9;
      if_r.data[9] = 32'h1234_5678;
      sb_push(32'h0);
      #1 sb_check("reg_no_stale", if_r.out);
      @(posedge clk);
      sb_push(32'h1234_5678);
      #1 sb_check("reg_after_rst", if_r.out);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
